master_in_port: RTL and testbench
=================================

# master_in_port

Serial receive stage that consumes the 1-bit LSB-first stream produced by the slave output port and turns it back into bytes. It owns `m_ready` on the handshake, samples 8 data bits per frame and checks framing against `s_tx_done`. Good bytes are buffered in a small FIFO that a downstream byte consumer drains through a valid/ready interface.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥ 2.
- `CNT_W`, default 16: width of the received-byte counter.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `s_valid` in 1: slave has a byte to send.
- `rx_data` in 1: serial data bit from the slave.
- `s_tx_done` in 1: slave last-bit marker, used for framing check.
- `m_ready` out 1: receiver can accept a frame; combinational.
- `m_data` out 8: head-of-FIFO byte.
- `m_valid` out 1: FIFO not empty.
- `d_ready` in 1: downstream accepts `m_data`.
- `frame_err` out 1: one-cycle pulse when a frame is discarded.
- `byte_count` out CNT_W: good bytes written to FIFO; saturating.

## Operation
- States: IDLE and RX.
- `m_ready = (state == IDLE) && (count < DEPTH)`.
- IDLE:
  - On an edge with `s_valid && m_ready`, go to RX and set `bit_cnt = 0`.
  - `rx_data` is not sampled on the handshake edge.
- RX, each edge:
  - `shreg <= {rx_data, shreg[7:1]}`, so the first sampled bit lands in bit 0; then `bit_cnt++`.
  - Samples with `bit_cnt` 0..6 must see `s_tx_done = 0`.
  - The sample with `bit_cnt = 7` must see `s_tx_done = 1`.
- RX, on the `bit_cnt = 7` edge:
  - Always return to IDLE.
  - If framing is good: push `{rx_data, shreg[7:1]}` to the FIFO and increment `byte_count`, saturating at all-ones.
  - If framing is bad: no push, `frame_err <= 1` for one cycle.
- Early `s_tx_done = 1` at `bit_cnt` < 7:
  - Abort immediately: return to IDLE and pulse `frame_err`.
  - The remaining bits are ignored.
- FIFO:
  - First-word fall-through; `m_valid = !empty`; `m_data = mem[rd_ptr]`.
  - Pop on `m_valid && d_ready`.
  - Push and pop on the same edge leave `count` unchanged.
  - A push can never hit a full FIFO, because space was reserved at the handshake and at most one frame is in flight.
- Pointers are log2(DEPTH) bits and wrap naturally. `count` is log2(DEPTH)+1 bits.

## Timing
- Handshake sampled at edge E0. Data bit k is sampled at edge E(k+1), k = 0..7.
- Byte is visible on `m_data` with `m_valid = 1` after E8, i.e. 8 cycles after the handshake when the FIFO was empty.
- `m_ready` is 0 from E0 through E8. Earliest next handshake is E9, giving a 9-cycle frame period.
- `frame_err` is high for exactly the cycle after the detecting edge.
- Reset values:
  - state IDLE, `bit_cnt` 0, `shreg` 0.
  - FIFO empty: `m_valid = 0`, `m_data = 0`, since `mem` is reset to 0.
  - `frame_err = 0`, `byte_count = 0`.
  - `m_ready = 1` once `reset` deasserts.
- Reset mid-frame discards the partial byte and all FIFO contents, with no `frame_err`.

## Structure
- `serial_bus_pkg` holds:
  - the state enum `rx_state_t` (IDLE, RX);
  - `FRAME_BITS = 8`;
  - a shared byte typedef `byte_t`.
- Sub-module `sync_fifo` (params `WIDTH`, `DEPTH`; push/pop/full/empty/count). Async reset on `clk`.
- Top level keeps the FSM, shift register, framing check and counter.

## Test plan
- **Single frame:** slave sends 0xA5 with `d_ready = 1` → `m_data = 0xA5`, `m_valid` high one cycle after E8, `byte_count = 1`, `frame_err = 0`.
- **Back-to-back:** 0x01, 0x80, 0xFF with `s_valid` held high → handshakes at E0, E9, E18; bytes out in order; `byte_count = 3`.
- **Backpressure:** `d_ready = 0`, 5 bytes offered → `m_ready` stays 0 after the 4th frame completes. Raising `d_ready` pops one byte per cycle, and the 5th frame then proceeds.
- **Framing error:** force `s_tx_done = 1` at `bit_cnt = 4` → one-cycle `frame_err`, no push, IDLE next cycle. Separately, `s_tx_done = 0` at bit 7 → same response.
- **Push/pop collision:** FIFO holds 2 bytes, a frame completes on the same edge as a pop → `count` stays 2 and order is preserved.
- **Reset mid-frame:** assert `reset` at `bit_cnt = 3` with 2 bytes buffered → `m_valid = 0`, `byte_count = 0`, `frame_err = 0`, `m_ready = 1` after release; the next 0x3C frame is received correctly.

Source files
------------

// File: rtl/serial_bus_pkg.sv
// ----------------------------------------------------------------------------
// serial_bus_pkg
// Shared types and constants for the serial byte link between the slave output
// port and the master input port.
//   rx_state_t  : receiver FSM states (IDLE, RX)
//   FRAME_BITS  : data bits per serial frame
//   BIT_CNT_W   : width of a counter that indexes one frame's bits
//   byte_t      : one frame's worth of data
// ----------------------------------------------------------------------------
package serial_bus_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RX   = 1'b1
    } rx_state_t;

    localparam int FRAME_BITS = 8;
    localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

    typedef logic [FRAME_BITS-1:0] byte_t;

endpackage

// File: rtl/master_in_port_if.sv
// ----------------------------------------------------------------------------
// master_in_port_if
// Bundles the serial link from the slave, the byte stream towards the
// downstream consumer and the receiver status/debug outputs.
//
// Handshake semantics (both links):
//   serial link : a frame starts on the rising edge where s_valid && m_ready
//                 are both high; the next 8 edges each carry one data bit on
//                 rx_data, LSB first, with s_tx_done high only on the last bit.
//   byte stream : m_data is transferred on every rising edge where
//                 m_valid && d_ready; m_data/m_valid hold until then.
//
// Signals
//   s_valid, rx_data, s_tx_done : from the slave
//   m_ready                     : to the slave, receiver can take a frame
//   m_data, m_valid, d_ready    : byte stream towards the consumer
//   frame_err                   : one-cycle pulse when a frame is discarded
//   byte_count                  : saturating count of good bytes
//   dbg_state, dbg_fifo_count   : receiver FSM state and FIFO occupancy
// Modports
//   master : the receiver (master_in_port)
//   slave  : the environment driving the serial link / consuming bytes
// ----------------------------------------------------------------------------
interface master_in_port_if
    import serial_bus_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);

    localparam int FCNT_W = $clog2(DEPTH) + 1;

    logic              s_valid;
    logic              rx_data;
    logic              s_tx_done;
    logic              m_ready;
    byte_t             m_data;
    logic              m_valid;
    logic              d_ready;
    logic              frame_err;
    logic [CNT_W-1:0]  byte_count;
    rx_state_t         dbg_state;
    logic [FCNT_W-1:0] dbg_fifo_count;

    modport master (
        input  s_valid, rx_data, s_tx_done, d_ready,
        output m_ready, m_data, m_valid, frame_err, byte_count,
               dbg_state, dbg_fifo_count
    );

    modport slave (
        output s_valid, rx_data, s_tx_done, d_ready,
        input  m_ready, m_data, m_valid, frame_err, byte_count,
               dbg_state, dbg_fifo_count
    );

endinterface

// File: rtl/master_in_port_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO. rd_data always shows the head
// entry; storage is cleared on reset so rd_data reads 0 when empty after reset.
//   clk, reset : clock, asynchronous active-high reset
//   push       : write wr_data (ignored when full)
//   wr_data    : data to write
//   pop        : drop head entry (ignored when empty)
//   rd_data    : head entry
//   full/empty : occupancy flags
//   count      : number of stored entries (0..DEPTH)
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FCNT_W = PTR_W + 1;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0] count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count_q == FCNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wr_data;
            // DEPTH is a power of two, so pointers wrap by overflow.
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + FCNT_W'(1);
            2'b01:   count_d = count_q - FCNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/master_in_port.sv
// ----------------------------------------------------------------------------
// master_in_port
// Serial receive stage: accepts a frame from the slave output port, shifts in
// 8 LSB-first data bits, checks that s_tx_done marks exactly the last bit and
// buffers good bytes in a FIFO drained by a downstream valid/ready consumer.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : master_in_port_if.master (serial link, byte stream, status, debug)
// Parameters
//   DEPTH : FIFO entries, power of two, >= 2
//   CNT_W : width of the saturating good-byte counter
// ----------------------------------------------------------------------------
module master_in_port
    import serial_bus_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    master_in_port_if.master  bus
);

    localparam int FCNT_W = $clog2(DEPTH) + 1;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

    rx_state_t            state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    byte_t                shreg_q, shreg_d;
    logic                 frame_err_q, frame_err_d;
    logic [CNT_W-1:0]     byte_count_q, byte_count_d;

    logic                 m_ready;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    byte_t                fifo_rd_data;
    logic [FCNT_W-1:0]    fifo_count;

    // Space is reserved at the handshake: with only one frame in flight, a
    // frame accepted while the FIFO is not full can always be pushed.
    assign m_ready  = (state_q == IDLE) && !fifo_full;
    assign fifo_pop = !fifo_empty && bus.d_ready;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        frame_err_d  = 1'b0;
        byte_count_d = byte_count_q;
        fifo_push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // rx_data is not sampled on the handshake edge itself.
                if (bus.s_valid && m_ready) begin
                    state_d   = RX;
                    bit_cnt_d = '0;
                end
            end
            RX: begin
                shreg_d   = {bus.rx_data, shreg_q[FRAME_BITS-1:1]};
                bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = IDLE;
                    if (bus.s_tx_done) begin
                        fifo_push = 1'b1;
                        if (byte_count_q != '1) begin
                            byte_count_d = byte_count_q + CNT_W'(1);
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else if (bus.s_tx_done) begin
                    // Early end marker: drop the frame now, remaining bits
                    // arrive while IDLE and are ignored.
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            frame_err_q  <= 1'b0;
            byte_count_q <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            frame_err_q  <= frame_err_d;
            byte_count_q <= byte_count_d;
        end
    end

    // The pushed byte includes the bit sampled on the completing edge.
    sync_fifo #(
        .WIDTH (FRAME_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .wr_data (shreg_d),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign bus.m_ready        = m_ready;
    assign bus.m_data         = fifo_rd_data;
    assign bus.m_valid        = !fifo_empty;
    assign bus.frame_err      = frame_err_q;
    assign bus.byte_count     = byte_count_q;
    assign bus.dbg_state      = state_q;
    assign bus.dbg_fifo_count = fifo_count;

endmodule

// File: tb/tb_master_in_port.sv
// ----------------------------------------------------------------------------
// tb_master_in_port
// Directed bench for master_in_port. The frame driver pushes each good byte
// into exp_q when it starts the frame; an independent monitor compares every
// byte the DUT hands downstream against the head of exp_q.
// ----------------------------------------------------------------------------
module tb_master_in_port;
    import serial_bus_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    master_in_port_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    master_in_port #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         n_checks = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         good_model = 0;
    int         hs_cyc = 0;
    logic [7:0] exp_q[$];
    logic [7:0] bp_bytes[4] = '{8'h10, 8'h20, 8'h30, 8'h40};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!reset && bus.m_valid === 1'b1 && bus.d_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_unexpected: got byte 0x%0h, expected none (t=%0t)", bus.m_data, $time);
            end else begin
                check("sb_data", bus.m_data, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    // err_at < 0     : good frame
    // err_at 0..6    : s_tx_done raised early at that bit (frame aborts)
    // err_at 7       : s_tx_done missing on the last bit
    // lat_chk        : check m_valid after every bit edge (FIFO must start empty)
    // collide        : raise d_ready for the completing edge only
    task automatic send_frame(input logic [7:0] b, input int err_at,
                              input bit lat_chk, input bit collide);
        int n;
        bit good;
        good = (err_at < 0);
        if (good) exp_q.push_back(b);
        bus.s_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.m_ready !== 1'b1 && n < 200);
        if (bus.m_ready !== 1'b1) begin
            fail_now("handshake_timeout");
            bus.s_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        hs_cyc = cyc;
        for (int k = 0; k < 8; k++) begin
            bus.rx_data   = b[k];
            bus.s_tx_done = (k == 7);
            if (k == err_at) bus.s_tx_done = ~bus.s_tx_done;
            if (collide && k == 7) bus.d_ready = 1'b1;
            @(posedge clk); #1;
            if (collide && k == 7) bus.d_ready = 1'b0;
            if (lat_chk) check("latency_m_valid", bus.m_valid, (k == 7));
            if (err_at >= 0 && err_at < 7 && k == err_at) break;
        end
        bus.s_valid   = 1'b0;
        bus.rx_data   = 1'b0;
        bus.s_tx_done = 1'b0;
        if (good) good_model++;
        check("frame_err_at_end", bus.frame_err, !good);
        check("state_idle_at_end", bus.dbg_state, IDLE);
        check("byte_count", bus.byte_count, good_model);
        if (!good) begin
            check("err_m_ready", bus.m_ready, 1);
            @(posedge clk); #1;
            check("frame_err_one_cycle", bus.frame_err, 0);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
        check("drained_m_valid", bus.m_valid, 0);
    endtask

    // ---------------- directed tests ----------------
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t0;
        bus.s_valid   = 1'b0;
        bus.rx_data   = 1'b0;
        bus.s_tx_done = 1'b0;
        bus.d_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_data", bus.m_data, 0);
        check("rst_m_valid", bus.m_valid, 0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_m_ready", bus.m_ready, 1);
        check("rst_frame_err", bus.frame_err, 0);
        check("rst_byte_count", bus.byte_count, 0);
        check("rst_state", bus.dbg_state, IDLE);

        // Single frame with latency check.
        bus.d_ready = 1'b1;
        send_frame(8'hA5, -1, 1'b1, 1'b0);
        drain();

        // Back-to-back frames: handshakes 9 cycles apart.
        send_frame(8'h01, -1, 1'b0, 1'b0);
        t0 = hs_cyc;
        send_frame(8'h80, -1, 1'b0, 1'b0);
        check("b2b_gap_1", hs_cyc - t0, 9);
        t0 = hs_cyc;
        send_frame(8'hFF, -1, 1'b0, 1'b0);
        check("b2b_gap_2", hs_cyc - t0, 9);
        drain();

        // Framing errors: early end marker at bit 4, missing marker at bit 7.
        send_frame(8'h5A, 4, 1'b0, 1'b0);
        check("err_early_no_push", bus.m_valid, 0);
        send_frame(8'hC3, 7, 1'b0, 1'b0);
        check("err_late_no_push", bus.m_valid, 0);

        // Backpressure: four bytes fill the FIFO, the fifth waits.
        bus.d_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_frame(bp_bytes[i], -1, 1'b0, 1'b0);
        check("bp_full_count", bus.dbg_fifo_count, 4);
        fork
            send_frame(8'h99, -1, 1'b0, 1'b0);
            begin
                repeat (3) begin
                    @(posedge clk); #1;
                    check("bp_m_ready_low", bus.m_ready, 0);
                end
                bus.d_ready = 1'b1;
                for (int i = 3; i >= 1; i--) begin
                    @(posedge clk); #1;
                    check("bp_pop_count", bus.dbg_fifo_count, i);
                end
            end
        join
        drain();

        // Push/pop collision with two bytes buffered.
        bus.d_ready = 1'b0;
        send_frame(8'h21, -1, 1'b0, 1'b0);
        send_frame(8'h42, -1, 1'b0, 1'b0);
        send_frame(8'h63, -1, 1'b0, 1'b1);
        check("collision_count", bus.dbg_fifo_count, 2);
        bus.d_ready = 1'b1;
        drain();

        // Reset in the middle of a frame with two bytes buffered.
        bus.d_ready = 1'b0;
        send_frame(8'h11, -1, 1'b0, 1'b0);
        send_frame(8'h22, -1, 1'b0, 1'b0);
        bus.s_valid = 1'b1;
        @(negedge clk);
        check("rst_mid_hs_ready", bus.m_ready, 1);
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.rx_data = k[0];
            @(posedge clk); #1;
        end
        check("rst_mid_in_rx", bus.dbg_state, RX);
        reset = 1'b1;
        exp_q.delete();
        good_model = 0;
        #1;
        check("rst_mid_m_valid_async", bus.m_valid, 0);
        bus.rx_data = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_m_valid", bus.m_valid, 0);
        check("rst_mid_byte_count", bus.byte_count, 0);
        check("rst_mid_frame_err", bus.frame_err, 0);
        check("rst_mid_m_ready", bus.m_ready, 1);
        check("rst_mid_state", bus.dbg_state, IDLE);
        bus.d_ready = 1'b1;
        send_frame(8'h3C, -1, 1'b0, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
